pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB). Drives the enables and flushes of the stage buffers.
//  Selects EX operand forwarding, detects load-use hazards and holds the pipe for multi-cycle DIV.
//  Squashes wrong-path instructions on a taken branch. Sits beside instructionDecode and ALU and owns every buffer en/rst.
// PARAMETERS
//  REG_W        4  register index width (16 GPRs; r0 is a normal register, not hardwired zero)
//  DIV_CYCLES   8  EX occupancy of a DIV, in cycles (>=2)
//  CNT_W        4  width of the DIV counter; must satisfy 2**CNT_W > DIV_CYCLES
// PORTS
//  clk           in   1      pipeline clock, rising edge
//  rst           in   1      asynchronous, active-high reset
//  id_ra,id_rb   in   REG_W  source registers of the instruction in ID
//  id_use_ra/rb  in   1      ID instruction actually reads ra/rb
//  idex_valid    in   1      ID/EX buffer holds a real instruction
//  idex_ra,rb    in   REG_W  sources of the instruction in EX
//  idex_rd       in   REG_W  destination of the instruction in EX
//  idex_wr       in   1      EX instruction writes idex_rd
//  idex_is_load  in   1      EX instruction is LD
//  idex_is_div   in   1      EX instruction is DIV
//  exmem_rd,wr   in   REG_W,1  destination and write flag in MEM
//  memwb_rd,wr   in   REG_W,1  destination and write flag in WB
//  br_taken      in   1      EX resolved a taken branch this cycle
//  en_pc         out  1      PC register enable
//  en_ifid       out  1      IF/ID buffer enable
//  en_idex       out  1      ID/EX buffer enable
//  en_exmem      out  1      EX/MEM buffer enable
//  flush_ifid    out  1      synchronous clear of IF/ID (loads NOP = all-zero word)
//  flush_idex    out  1      synchronous clear of ID/EX (bubble)
//  flush_exmem   out  1      synchronous clear of EX/MEM
//  fwd_a,fwd_b   out  2      EX operand source: 00 regfile, 01 EX/MEM, 10 MEM/WB
//  div_busy      out  1      DIV in progress
// BEHAVIOUR
//  State:
//   - Registered FSM {RUN, DIV_WAIT}. Down-counter cnt[CNT_W-1:0].
//   - Reset: state=RUN, cnt=0.
//   - While rst=1, every output is 0 (combinationally gated): all enables low, flushes low, fwd=00.
//  Forwarding (combinational, every cycle):
//   - fwd_a=01 if exmem_wr && exmem_rd==idex_ra.
//   - Else fwd_a=10 if memwb_wr && memwb_rd==idex_ra.
//   - Else fwd_a=00. fwd_b is identical using idex_rb.
//   - EX/MEM wins when both match.
//  RUN, priority highest first:
//   1. br_taken: flush_ifid=1, flush_idex=1. All enables 1.
//      Two wrong-path instructions are squashed and the PC loads the target.
//   2. idex_valid && idex_is_div:
//      - Go to DIV_WAIT; cnt<=DIV_CYCLES-2.
//      - en_pc=en_ifid=en_idex=en_exmem=0; div_busy=1.
//   3. Load-use hazard (idex_valid && idex_is_load && idex_wr, and idex_rd matches id_ra with id_use_ra or id_rb with id_use_rb):
//      - en_pc=en_ifid=0, flush_idex=1, en_exmem=1.
//      - Exactly one bubble per hazard. The next cycle re-evaluates with the LD in MEM, and forwarding 01 resolves it.
//   4. Otherwise: all enables 1, no flush.
//  DIV_WAIT:
//   - All enables 0, div_busy=1, cnt decrements.
//   - When cnt==0: enables 1, flush_exmem=0, state<=RUN. The DIV leaves EX that edge.
//   - Total EX occupancy is exactly DIV_CYCLES cycles.
//   - br_taken and hazard inputs are ignored in DIV_WAIT (EX holds the DIV, so no branch can resolve).
//  Boundaries:
//   - Back-to-back DIVs: the second re-enters DIV_WAIT on its first EX cycle. There is no idle cycle between them.
//   - A load-use hazard behind a DIV is detected in the first RUN cycle after the DIV exits.
//   - Async rst mid-DIV: returns to RUN immediately and the counter clears.
//   - The first edge after rst falls runs in RUN with all enables 1.
// STRUCTURE
//  hazard_pkg:
//   - typedef enum logic {RUN, DIV_WAIT} hz_state_t
//   - localparams FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10
//  One sub-module: stall_counter #(CNT_W) (load, load value, dec, zero flag, async rst).
//  All remaining logic is a single always_ff for state plus always_comb for outputs.
// TESTING
//  1. Reset:
//     - rst=1 with br_taken=1 -> all outputs 0.
//     - Release rst -> en_pc=1, flushes 0, fwd 00.
//  2. Forwarding:
//     - idex_ra=3, exmem_rd=3/wr=1, memwb_rd=3/wr=1 -> fwd_a=01.
//     - Then exmem_wr=0 -> fwd_a=10.
//     - idex_rb=7, no match -> fwd_b=00.
//  3. Load-use:
//     - EX holds LD r15 (is_load, rd=15); ID reads id_rb=15 with use_rb=1 -> 1 cycle en_pc=0, en_ifid=0, flush_idex=1.
//     - Next cycle all enables 1.
//     - Same case with use_rb=0 -> no stall.
//  4. DIV:
//     - idex_is_div=1 -> div_busy high exactly DIV_CYCLES-1 cycles after entry plus the entry cycle (8 total, default).
//     - All enables low for 7 cycles; enables return high on cycle 8.
//     - Back-to-back DIV -> 16 consecutive busy cycles.
//  5. Branch: br_taken=1 in RUN with a simultaneous load-use hazard -> flush_ifid=flush_idex=1, en_pc=1; no stall cycle.
//  6. rst pulse in the 4th DIV_WAIT cycle -> div_busy=0 immediately; after release, normal RUN behaviour.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package hazard_pkg;

  typedef enum logic {RUN, DIV_WAIT} hz_state_t;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // The youngest producer (EX/MEM) wins when both later stages match.
  function automatic logic [1:0] fwd_sel(input logic exmem_hit, input logic memwb_hit);
    if (exmem_hit) return FWD_EXMEM;
    if (memwb_hit) return FWD_MEMWB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/stall_counter.sv
// Loadable down-counter with zero flag, used to time multi-cycle EX occupancy.
module stall_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central 5-stage pipeline sequencer: forwarding select, load-use bubbles, DIV hold and
// taken-branch squash. Owns every stage-buffer enable and flush.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W      = 4,
  parameter int unsigned DIV_CYCLES = 8,
  parameter int unsigned CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] i_id_ra,
  input  logic [REG_W-1:0] i_id_rb,
  input  logic             i_id_use_ra,
  input  logic             i_id_use_rb,
  input  logic             i_idex_valid,
  input  logic [REG_W-1:0] i_idex_ra,
  input  logic [REG_W-1:0] i_idex_rb,
  input  logic [REG_W-1:0] i_idex_rd,
  input  logic             i_idex_wr,
  input  logic             i_idex_is_load,
  input  logic             i_idex_is_div,
  input  logic [REG_W-1:0] i_exmem_rd,
  input  logic             i_exmem_wr,
  input  logic [REG_W-1:0] i_memwb_rd,
  input  logic             i_memwb_wr,
  input  logic             i_br_taken,
  output logic             o_en_pc,
  output logic             o_en_ifid,
  output logic             o_en_idex,
  output logic             o_en_exmem,
  output logic             o_flush_ifid,
  output logic             o_flush_idex,
  output logic             o_flush_exmem,
  output logic [1:0]       o_fwd_a,
  output logic [1:0]       o_fwd_b,
  output logic             o_div_busy
);

  // Entry cycle is spent in RUN, so the wait phase covers the remaining DIV_CYCLES-1.
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

  hz_state_t r_state, w_state_d;
  logic      w_cnt_zero, w_div_start, w_ld_use, w_cnt_load, w_cnt_dec;

  assign w_div_start = i_idex_valid & i_idex_is_div;
  assign w_ld_use    = i_idex_valid & i_idex_is_load & i_idex_wr &
                       ((i_id_use_ra & (i_idex_rd == i_id_ra)) |
                        (i_id_use_rb & (i_idex_rd == i_id_rb)));

  assign w_cnt_load = (r_state == RUN) & ~i_br_taken & w_div_start;
  assign w_cnt_dec  = (r_state == DIV_WAIT) & ~w_cnt_zero;

  stall_counter #(
    .CNT_W (CNT_W)
  ) u_stall_counter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_load_val (DIV_LOAD),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      RUN:      if (w_cnt_load) w_state_d = DIV_WAIT;
      DIV_WAIT: if (w_cnt_zero) w_state_d = RUN;
      default:  w_state_d = RUN;
    endcase
  end

  always_comb begin
    o_en_pc       = 1'b0;
    o_en_ifid     = 1'b0;
    o_en_idex     = 1'b0;
    o_en_exmem    = 1'b0;
    o_flush_ifid  = 1'b0;
    o_flush_idex  = 1'b0;
    o_flush_exmem = 1'b0;
    o_fwd_a       = FWD_RF;
    o_fwd_b       = FWD_RF;
    o_div_busy    = 1'b0;
    if (!rst) begin
      o_fwd_a = fwd_sel(i_exmem_wr && i_exmem_rd == i_idex_ra,
                        i_memwb_wr && i_memwb_rd == i_idex_ra);
      o_fwd_b = fwd_sel(i_exmem_wr && i_exmem_rd == i_idex_rb,
                        i_memwb_wr && i_memwb_rd == i_idex_rb);
      unique case (r_state)
        RUN: begin
          if (i_br_taken) begin
            {o_en_pc, o_en_ifid, o_en_idex, o_en_exmem} = 4'b1111;
            o_flush_ifid = 1'b1;
            o_flush_idex = 1'b1;
          end else if (w_div_start) begin
            // EX/MEM is frozen, so clear it to stop MEM replaying the older instruction.
            o_flush_exmem = 1'b1;
            o_div_busy    = 1'b1;
          end else if (w_ld_use) begin
            o_en_idex    = 1'b1;
            o_en_exmem   = 1'b1;
            o_flush_idex = 1'b1;
          end else begin
            {o_en_pc, o_en_ifid, o_en_idex, o_en_exmem} = 4'b1111;
          end
        end
        DIV_WAIT: begin
          o_div_busy = 1'b1;
          if (w_cnt_zero) begin
            {o_en_pc, o_en_ifid, o_en_idex, o_en_exmem} = 4'b1111;
          end else begin
            o_flush_exmem = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Vector table plus hand-built DIV/reset sequences, checked through an expected-value queue.
module tb_pipeline_hazard_ctrl;

  localparam int DIV_CYCLES = 8;

  typedef struct packed {
    logic       rst;
    logic [3:0] id_ra, id_rb;
    logic       use_ra, use_rb, idex_valid;
    logic [3:0] idex_ra, idex_rb, idex_rd;
    logic       idex_wr, is_load, is_div;
    logic [3:0] exmem_rd;
    logic       exmem_wr;
    logic [3:0] memwb_rd;
    logic       memwb_wr, br;
  } in_t;

  typedef struct packed {
    logic       en_pc, en_ifid, en_idex, en_exmem;
    logic       fl_ifid, fl_idex, fl_exmem;
    logic [1:0] fa, fb;
    logic       busy;
  } out_t;

  typedef struct {
    in_t   i;
    out_t  e;
    string nm;
  } vec_t;

  localparam out_t O_ZERO   = '0;
  localparam out_t O_RUN    = {4'b1111, 3'b000, 2'b00, 2'b00, 1'b0};
  localparam out_t O_LU     = {4'b0011, 3'b010, 2'b00, 2'b00, 1'b0};
  localparam out_t O_BR     = {4'b1111, 3'b110, 2'b00, 2'b00, 1'b0};
  localparam out_t O_DIVST  = {4'b0000, 3'b001, 2'b00, 2'b00, 1'b1};
  localparam out_t O_DIVREL = {4'b1111, 3'b000, 2'b00, 2'b00, 1'b1};

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] id_ra, id_rb, idex_ra, idex_rb, idex_rd, exmem_rd, memwb_rd;
  logic       id_use_ra, id_use_rb, idex_valid, idex_wr, idex_is_load, idex_is_div;
  logic       exmem_wr, memwb_wr, br_taken;
  logic       en_pc, en_ifid, en_idex, en_exmem, flush_ifid, flush_idex, flush_exmem, div_busy;
  logic [1:0] fwd_a, fwd_b;
  out_t       act;

  int   n_vec = 0;
  int   n_err = 0;
  out_t exp_q[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .REG_W      (4),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_id_ra       (id_ra),
    .i_id_rb       (id_rb),
    .i_id_use_ra   (id_use_ra),
    .i_id_use_rb   (id_use_rb),
    .i_idex_valid  (idex_valid),
    .i_idex_ra     (idex_ra),
    .i_idex_rb     (idex_rb),
    .i_idex_rd     (idex_rd),
    .i_idex_wr     (idex_wr),
    .i_idex_is_load(idex_is_load),
    .i_idex_is_div (idex_is_div),
    .i_exmem_rd    (exmem_rd),
    .i_exmem_wr    (exmem_wr),
    .i_memwb_rd    (memwb_rd),
    .i_memwb_wr    (memwb_wr),
    .i_br_taken    (br_taken),
    .o_en_pc       (en_pc),
    .o_en_ifid     (en_ifid),
    .o_en_idex     (en_idex),
    .o_en_exmem    (en_exmem),
    .o_flush_ifid  (flush_ifid),
    .o_flush_idex  (flush_idex),
    .o_flush_exmem (flush_exmem),
    .o_fwd_a       (fwd_a),
    .o_fwd_b       (fwd_b),
    .o_div_busy    (div_busy)
  );

  assign act = {en_pc, en_ifid, en_idex, en_exmem, flush_ifid, flush_idex, flush_exmem,
                fwd_a, fwd_b, div_busy};

  task automatic apply(input in_t v, input out_t e, input string nm);
    out_t x;
    rst = v.rst;           id_ra = v.id_ra;           id_rb = v.id_rb;
    id_use_ra = v.use_ra;  id_use_rb = v.use_rb;      idex_valid = v.idex_valid;
    idex_ra = v.idex_ra;   idex_rb = v.idex_rb;       idex_rd = v.idex_rd;
    idex_wr = v.idex_wr;   idex_is_load = v.is_load;  idex_is_div = v.is_div;
    exmem_rd = v.exmem_rd; exmem_wr = v.exmem_wr;
    memwb_rd = v.memwb_rd; memwb_wr = v.memwb_wr;     br_taken = v.br;
    exp_q.push_back(e);
    @(negedge clk);
    x = exp_q.pop_front();
    n_vec++;
    if (act !== x) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (en4 fl3 fa fb busy)", nm, act, x);
    end
    @(posedge clk);
    #1;
  endtask

  // One DIV per entry, EX holding it throughout; branch noise in the wait cycles must be ignored.
  task automatic run_div(input int n_div, input string tag);
    in_t d, w;
    d = '0; d.idex_valid = 1'b1; d.is_div = 1'b1;
    w = d;  w.br = 1'b1;
    for (int k = 0; k < n_div; k++) begin
      apply(d, O_DIVST, {tag, "_entry"});
      for (int c = 1; c <= DIV_CYCLES - 2; c++) apply(w, O_DIVST, {tag, "_wait"});
      apply(w, O_DIVREL, {tag, "_release"});
    end
  endtask

  initial begin
    in_t  v, l, d;
    out_t e;

    v = '0; v.rst = 1'b1; v.br = 1'b1;
    tbl.push_back('{v, O_ZERO, "reset_gate"});
    v = '0;
    tbl.push_back('{v, O_RUN, "reset_release"});
    v = '0; v.idex_ra = 4'd3; v.exmem_rd = 4'd3; v.exmem_wr = 1'b1;
    v.memwb_rd = 4'd3; v.memwb_wr = 1'b1;
    e = O_RUN; e.fa = 2'b01;
    tbl.push_back('{v, e, "fwd_a_exmem_wins"});
    v.exmem_wr = 1'b0; e.fa = 2'b10;
    tbl.push_back('{v, e, "fwd_a_memwb"});
    v = '0; v.idex_ra = 4'd5; v.idex_rb = 4'd7; v.exmem_rd = 4'd3; v.exmem_wr = 1'b1;
    v.memwb_rd = 4'd5; v.memwb_wr = 1'b1;
    e = O_RUN; e.fa = 2'b10;
    tbl.push_back('{v, e, "fwd_b_nomatch"});
    v = '0; v.idex_rb = 4'd9; v.exmem_rd = 4'd9; v.exmem_wr = 1'b1;
    e = O_RUN; e.fb = 2'b01;
    tbl.push_back('{v, e, "fwd_b_exmem"});
    v = '0; v.idex_rb = 4'd9; v.memwb_rd = 4'd9; v.memwb_wr = 1'b1;
    e = O_RUN; e.fb = 2'b10;
    tbl.push_back('{v, e, "fwd_b_memwb"});
    l = '0; l.idex_valid = 1'b1; l.is_load = 1'b1; l.idex_wr = 1'b1; l.idex_rd = 4'd15;
    l.id_rb = 4'd15; l.use_rb = 1'b1;
    tbl.push_back('{l, O_LU, "load_use_rb"});
    v = '0; v.idex_ra = 4'd15; v.exmem_rd = 4'd15; v.exmem_wr = 1'b1;
    e = O_RUN; e.fa = 2'b01;
    tbl.push_back('{v, e, "load_use_resolved"});
    v = l; v.use_rb = 1'b0;
    tbl.push_back('{v, O_RUN, "load_no_use"});
    v = l; v.idex_wr = 1'b0;
    tbl.push_back('{v, O_RUN, "load_no_wr"});
    v = l; v.use_rb = 1'b0; v.id_rb = 4'd0; v.id_ra = 4'd15; v.use_ra = 1'b1;
    tbl.push_back('{v, O_LU, "load_use_ra"});
    v = l; v.idex_valid = 1'b0;
    tbl.push_back('{v, O_RUN, "load_invalid"});
    v = l; v.br = 1'b1;
    tbl.push_back('{v, O_BR, "branch_over_load_use"});
    v = '0;
    tbl.push_back('{v, O_RUN, "post_branch"});

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i].i, tbl[i].e, tbl[i].nm);

    run_div(1, "div");
    apply('0, O_RUN, "div_exit_run");
    run_div(2, "div_b2b");
    apply('0, O_RUN, "b2b_exit_run");
    run_div(1, "div_lu");
    apply(l, O_LU, "load_use_after_div");
    apply('0, O_RUN, "lu_after_div_done");

    d = '0; d.idex_valid = 1'b1; d.is_div = 1'b1;
    apply(d, O_DIVST, "rstdiv_entry");
    for (int c = 1; c <= 3; c++) apply(d, O_DIVST, "rstdiv_wait");
    v = d; v.rst = 1'b1;
    apply(v, O_ZERO, "rst_mid_div");
    apply('0, O_RUN, "after_rst_run");
    run_div(1, "div_after_rst");
    apply('0, O_RUN, "final_run");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
